execute: RTL and testbench
==========================

# execute

Execute stage of the five-stage MIPS pipeline: the consumer of the ID/EX register that decode drives. It applies forwarding, evaluates the ALU or link address, and selects the destination register. It also runs an iterative multiply/divide unit with HI/LO registers. Results and M/W controls are registered into the EX/MEM pipeline register feeding the memory stage. It raises a stall toward fetch/decode while a HI/LO-dependent op waits on the multiply/divide unit.

## Interface
- Parameters: none.
- Clock and reset: `i_clk` is the clock. Reset is `i_nrst`, asynchronous, active-low.

Ports (name, direction, width, meaning):
- i_clk  in  1  clock
- i_nrst  in  1  async active-low reset
- i_data_rs, i_data_rt  in  32  ID/EX operand values
- i_data_imm  in  32  sign/zero-extended immediate; [10:6] is shamt
- i_addr_rs, i_addr_rt, i_addr_rd  in  5  register addresses
- i_addr_pc4  in  32  PC+4 of the instruction
- i_con_Ealuop  in  6  operation code (see Operation)
- i_con_Ealusrc  in  1  B operand: 1 = imm, 0 = forwarded rt
- i_con_Eregdst  in  1  destination select
- i_con_Ealupc4  in  1  result = link address
- i_con_Mmemread, i_con_Mmemwrite  in  1  passed to M
- i_con_Wloadmux  in  2  passed to W
- i_con_Wmemtoreg, i_con_Wregwrite  in  1  passed to W
- i_data_Mfwd, i_data_Wfwd  in  32  forwarding sources from M and W
- i_con_fwda, i_con_fwdb  in  2  forward select: 00 ID/EX, 01 W, 10 M, 11 reserved (treated as 00)
- o_data_alu  out  32  registered result
- o_data_wrt  out  32  registered store data (forwarded rt)
- o_addr_dst  out  5  registered destination register
- o_con_Mmemread, o_con_Mmemwrite, o_con_Wloadmux, o_con_Wmemtoreg, o_con_Wregwrite  out  1/1/2/1/1  registered controls
- o_con_stall  out  1  combinational; hold PC, IF/ID and ID/EX

## Operation
- Operands: A = fwd(rs); B = Ealusrc ? imm : fwd(rt).
- Aluop codes:
  - 0x20/0x21 add
  - 0x22/0x23 sub
  - 0x24 and, 0x25 or, 0x26 xor, 0x27 nor
  - 0x2A slt (signed), 0x2B sltu
  - 0x00 sll B by shamt, 0x02 srl, 0x03 sra
  - 0x0F lui: B<<16
  - 0x10 mfhi, 0x12 mflo
  - 0x18 mult, 0x19 multu, 0x1A div, 0x1B divu
  - any other code: result 0
- Arithmetic: all arithmetic is modulo 2^32 with no overflow trap.
- Link: when Ealupc4=1, result = i_addr_pc4+4. dst = Eregdst ? rd : 31.
- Destination when Ealupc4=0: dst = Eregdst ? rd : rt.
- MD unit states and transitions:
  - IDLE → BUSY: a mult/div op is in EX and not stalled. Operand magnitudes, signs and op type are latched; counter = 0.
  - BUSY: one shift-add (mult) or restoring-subtract (div) step per cycle.
  - BUSY → DONE: at counter = 31, with the step result written to HI/LO in that same cycle (sign-corrected for signed ops).
  - DONE → IDLE: unconditional, next cycle.
- MD results:
  - mult: HI:LO = 64-bit product.
  - div: LO = quotient, HI = remainder. The remainder takes the sign of the dividend.
  - Divide by zero: LO = 0xFFFFFFFF, HI = dividend; takes the full 32 cycles.
- The write to EX/MEM for a mult/div op carries o_con_Wregwrite=0.
- Stall rule: o_con_stall = (state≠IDLE) & (aluop ∈ {mfhi, mflo, mult, multu, div, divu}). Other ops proceed under a busy unit.
- While stalled, EX/MEM loads a bubble: all M/W controls 0, data and dst 0.

## Timing
- Reset: every output 0; HI, LO = 0; MD state IDLE. Reset mid-operation aborts the op, with HI/LO = 0.
- Non-MD ops: 1-cycle latency, ID/EX → EX/MEM on the next rising edge.
- MD op issued in cycle N:
  - BUSY in cycles N+1..N+32.
  - HI/LO valid from the edge ending N+32.
  - IDLE again at N+34; an mfhi in EX at N+34 completes.
  - A dependent mfhi directly after the op stalls cycles N+1..N+33.
- Forwarding muxes are purely combinational, within the EX cycle.

## Configuration
- `EXEC_MULDIV_EN` defined:
  - MD unit, HI/LO and stall logic present as above.
- Undefined:
  - No MD unit and no HI/LO.
  - mult/div codes behave as unknown (result 0, Wregwrite passed through).
  - mfhi/mflo return 0.
  - o_con_stall is tied 0.

## Test plan
- Reset asserted mid-cycle → all outputs 0 asynchronously; after release, add rs=5, rt=7, Eregdst=1, rd=3 → next edge o_data_alu=12, o_addr_dst=3, o_con_Wregwrite=1.
- Forwarding: fwda=10 with Mfwd=0x100, fwdb=01 with Wfwd=0x1, sub → 0xFF; o_data_wrt=0x1.
- slt −1,1 → 1; sltu 0xFFFFFFFF,1 → 0; sra 0x80000000 by 4 → 0xF8000000; lui imm 0x1234 → 0x12340000.
- jal: Ealupc4=1, Eregdst=0, pc4=0x400 → o_data_alu=0x404, o_addr_dst=31.
- mult −3×7, then mflo back-to-back → stall high 33 cycles, then LO=0xFFFFFFEB, mfhi=0xFFFFFFFF; an independent add during BUSY is not stalled.
- div −7/2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF; divu 5/0 → LO=0xFFFFFFFF, HI=5; reset at BUSY cycle 10 → HI=LO=0, stall 0.

Source files
------------

// File: rtl/execute.sv
// MIPS execute stage: forwarding, ALU/link, dst select, EX/MEM register; optional iterative mul/div + HI/LO under `EXEC_MULDIV_EN.
// Latency: 1 cycle for ALU ops; mul/div occupies the unit 32 busy cycles plus one done cycle.
// Backpressure: o_con_stall (combinational) holds upstream while a HI/LO-dependent op meets a busy unit; EX/MEM takes a bubble.
module execute (
    input  logic        i_clk,
    input  logic        i_nrst,
    input  logic [31:0] i_data_rs,
    input  logic [31:0] i_data_rt,
    input  logic [31:0] i_data_imm,
    input  logic [4:0]  i_addr_rs,
    input  logic [4:0]  i_addr_rt,
    input  logic [4:0]  i_addr_rd,
    input  logic [31:0] i_addr_pc4,
    input  logic [5:0]  i_con_Ealuop,
    input  logic        i_con_Ealusrc,
    input  logic        i_con_Eregdst,
    input  logic        i_con_Ealupc4,
    input  logic        i_con_Mmemread,
    input  logic        i_con_Mmemwrite,
    input  logic [1:0]  i_con_Wloadmux,
    input  logic        i_con_Wmemtoreg,
    input  logic        i_con_Wregwrite,
    input  logic [31:0] i_data_Mfwd,
    input  logic [31:0] i_data_Wfwd,
    input  logic [1:0]  i_con_fwda,
    input  logic [1:0]  i_con_fwdb,
    output logic [31:0] o_data_alu,
    output logic [31:0] o_data_wrt,
    output logic [4:0]  o_addr_dst,
    output logic        o_con_Mmemread,
    output logic        o_con_Mmemwrite,
    output logic [1:0]  o_con_Wloadmux,
    output logic        o_con_Wmemtoreg,
    output logic        o_con_Wregwrite,
    output logic        o_con_stall
);
    logic [31:0] op_a, op_b, rt_fwd, alu_res, hi_val, lo_val;
    logic [4:0]  shamt, dst;
    logic        md_block_wr;
    logic        unused_addr_rs;

    // Hazard detection happens upstream, so the rs address is not needed here.
    assign unused_addr_rs = ^i_addr_rs;

    function automatic logic [31:0] fwd_mux(input logic [1:0] sel, input logic [31:0] idex,
                                            input logic [31:0] m, input logic [31:0] w);
        case (sel)
            2'b10:   return m;
            2'b01:   return w;
            default: return idex;
        endcase
    endfunction

    assign op_a   = fwd_mux(i_con_fwda, i_data_rs, i_data_Mfwd, i_data_Wfwd);
    assign rt_fwd = fwd_mux(i_con_fwdb, i_data_rt, i_data_Mfwd, i_data_Wfwd);
    assign op_b   = i_con_Ealusrc ? i_data_imm : rt_fwd;
    assign shamt  = i_data_imm[10:6];

    always_comb begin
        alu_res = 32'd0;
        if (i_con_Ealupc4) begin
            alu_res = i_addr_pc4 + 32'd4;
        end else begin
            case (i_con_Ealuop)
                6'h20, 6'h21: alu_res = op_a + op_b;
                6'h22, 6'h23: alu_res = op_a - op_b;
                6'h24:        alu_res = op_a & op_b;
                6'h25:        alu_res = op_a | op_b;
                6'h26:        alu_res = op_a ^ op_b;
                6'h27:        alu_res = ~(op_a | op_b);
                6'h2A:        alu_res = {31'd0, $signed(op_a) < $signed(op_b)};
                6'h2B:        alu_res = {31'd0, op_a < op_b};
                6'h00:        alu_res = op_b << shamt;
                6'h02:        alu_res = op_b >> shamt;
                6'h03:        alu_res = $signed(op_b) >>> shamt;
                6'h0F:        alu_res = {op_b[15:0], 16'h0000};
                6'h10:        alu_res = hi_val;
                6'h12:        alu_res = lo_val;
                default:      alu_res = 32'd0;
            endcase
        end
        dst = i_con_Eregdst ? i_addr_rd : (i_con_Ealupc4 ? 5'd31 : i_addr_rt);
    end

`ifdef EXEC_MULDIV_EN
    typedef enum logic [1:0] {MD_IDLE, MD_BUSY, MD_DONE} md_state_t;
    md_state_t   state_q, state_d;
    logic [4:0]  cnt_q;
    logic [31:0] acc_q, wrk_q, opnd_q, hi_q, lo_q;
    logic [31:0] acc_nxt, wrk_nxt, mag_a, mag_b;
    logic [32:0] sum, r_sh;
    logic [63:0] prod;
    logic        is_md, is_hilo, start, last, ge, sgn_op, sa, sb;
    logic        is_div_q, neg_lo_q, neg_hi_q;

    assign is_md   = (i_con_Ealuop[5:2] == 4'b0110);
    assign is_hilo = is_md | (i_con_Ealuop == 6'h10) | (i_con_Ealuop == 6'h12);
    assign sgn_op  = ~i_con_Ealuop[0];
    assign sa      = sgn_op & op_a[31];
    assign sb      = sgn_op & op_b[31];
    assign mag_a   = sa ? -op_a : op_a;
    assign mag_b   = sb ? -op_b : op_b;

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) state_q <= MD_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            MD_IDLE: if (start) state_d = MD_BUSY;
            MD_BUSY: if (last)  state_d = MD_DONE;
            default:            state_d = MD_IDLE;
        endcase
    end

    always_comb begin
        start       = (state_q == MD_IDLE) & is_md;
        last        = (state_q == MD_BUSY) & (cnt_q == 5'd31);
        o_con_stall = (state_q != MD_IDLE) & is_hilo;
        md_block_wr = is_md;
    end

    // Mult: acc is the running high half, wrk shifts the multiplier out and product bits in.
    // Div: acc is the partial remainder, wrk shifts the dividend out and quotient bits in.
    always_comb begin
        sum  = {1'b0, acc_q} + (wrk_q[0] ? {1'b0, opnd_q} : 33'd0);
        r_sh = {acc_q, wrk_q[31]};
        ge   = (r_sh >= {1'b0, opnd_q});
        if (is_div_q) begin
            acc_nxt = ge ? (r_sh[31:0] - opnd_q) : r_sh[31:0];
            wrk_nxt = {wrk_q[30:0], ge};
        end else begin
            acc_nxt = sum[32:1];
            wrk_nxt = {sum[0], wrk_q[31:1]};
        end
        prod = neg_lo_q ? -{acc_nxt, wrk_nxt} : {acc_nxt, wrk_nxt};
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            cnt_q    <= 5'd0;
            acc_q    <= 32'd0;
            wrk_q    <= 32'd0;
            opnd_q   <= 32'd0;
            is_div_q <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
        end else if (start) begin
            cnt_q    <= 5'd0;
            acc_q    <= 32'd0;
            is_div_q <= i_con_Ealuop[1];
            if (i_con_Ealuop[1]) begin
                wrk_q    <= mag_a;
                opnd_q   <= mag_b;
                // Divide by zero keeps the all-ones quotient unsigned.
                neg_lo_q <= (sa ^ sb) & (op_b != 32'd0);
                neg_hi_q <= sa;
            end else begin
                wrk_q    <= mag_b;
                opnd_q   <= mag_a;
                neg_lo_q <= sa ^ sb;
                neg_hi_q <= 1'b0;
            end
        end else if (state_q == MD_BUSY) begin
            cnt_q <= cnt_q + 5'd1;
            acc_q <= acc_nxt;
            wrk_q <= wrk_nxt;
            if (last) begin
                if (is_div_q) begin
                    lo_q <= neg_lo_q ? -wrk_nxt : wrk_nxt;
                    hi_q <= neg_hi_q ? -acc_nxt : acc_nxt;
                end else begin
                    lo_q <= prod[31:0];
                    hi_q <= prod[63:32];
                end
            end
        end
    end

    assign hi_val = hi_q;
    assign lo_val = lo_q;
`else
    assign o_con_stall = 1'b0;
    assign md_block_wr = 1'b0;
    assign hi_val      = 32'd0;
    assign lo_val      = 32'd0;
`endif

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst || o_con_stall) begin
            o_data_alu      <= 32'd0;
            o_data_wrt      <= 32'd0;
            o_addr_dst      <= 5'd0;
            o_con_Mmemread  <= 1'b0;
            o_con_Mmemwrite <= 1'b0;
            o_con_Wloadmux  <= 2'd0;
            o_con_Wmemtoreg <= 1'b0;
            o_con_Wregwrite <= 1'b0;
        end else begin
            o_data_alu      <= alu_res;
            o_data_wrt      <= rt_fwd;
            o_addr_dst      <= dst;
            o_con_Mmemread  <= i_con_Mmemread;
            o_con_Mmemwrite <= i_con_Mmemwrite;
            o_con_Wloadmux  <= i_con_Wloadmux;
            o_con_Wmemtoreg <= i_con_Wmemtoreg;
            o_con_Wregwrite <= i_con_Wregwrite & ~md_block_wr;
        end
    end
endmodule

// File: tb/tb_execute.sv
// Directed bench for execute; mul/div section follows EXEC_MULDIV_EN.
module tb_execute;
    logic        i_clk = 1'b0;
    logic        i_nrst;
    logic [31:0] i_data_rs, i_data_rt, i_data_imm, i_addr_pc4, i_data_Mfwd, i_data_Wfwd;
    logic [4:0]  i_addr_rs, i_addr_rt, i_addr_rd;
    logic [5:0]  i_con_Ealuop;
    logic        i_con_Ealusrc, i_con_Eregdst, i_con_Ealupc4;
    logic        i_con_Mmemread, i_con_Mmemwrite, i_con_Wmemtoreg, i_con_Wregwrite;
    logic [1:0]  i_con_Wloadmux, i_con_fwda, i_con_fwdb;
    logic [31:0] o_data_alu, o_data_wrt;
    logic [4:0]  o_addr_dst;
    logic        o_con_Mmemread, o_con_Mmemwrite, o_con_Wmemtoreg, o_con_Wregwrite, o_con_stall;
    logic [1:0]  o_con_Wloadmux;

    int n_tests = 0;
    int n_fail  = 0;

    execute dut (
        .i_clk(i_clk), .i_nrst(i_nrst),
        .i_data_rs(i_data_rs), .i_data_rt(i_data_rt), .i_data_imm(i_data_imm),
        .i_addr_rs(i_addr_rs), .i_addr_rt(i_addr_rt), .i_addr_rd(i_addr_rd),
        .i_addr_pc4(i_addr_pc4), .i_con_Ealuop(i_con_Ealuop), .i_con_Ealusrc(i_con_Ealusrc),
        .i_con_Eregdst(i_con_Eregdst), .i_con_Ealupc4(i_con_Ealupc4),
        .i_con_Mmemread(i_con_Mmemread), .i_con_Mmemwrite(i_con_Mmemwrite),
        .i_con_Wloadmux(i_con_Wloadmux), .i_con_Wmemtoreg(i_con_Wmemtoreg),
        .i_con_Wregwrite(i_con_Wregwrite), .i_data_Mfwd(i_data_Mfwd), .i_data_Wfwd(i_data_Wfwd),
        .i_con_fwda(i_con_fwda), .i_con_fwdb(i_con_fwdb),
        .o_data_alu(o_data_alu), .o_data_wrt(o_data_wrt), .o_addr_dst(o_addr_dst),
        .o_con_Mmemread(o_con_Mmemread), .o_con_Mmemwrite(o_con_Mmemwrite),
        .o_con_Wloadmux(o_con_Wloadmux), .o_con_Wmemtoreg(o_con_Wmemtoreg),
        .o_con_Wregwrite(o_con_Wregwrite), .o_con_stall(o_con_stall)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic clear(input logic [5:0] op, input logic [31:0] rs, input logic [31:0] rt);
        i_con_Ealuop = op;   i_data_rs = rs;      i_data_rt = rt;
        i_data_imm = 32'd0;  i_addr_pc4 = 32'd0;  i_data_Mfwd = 32'd0; i_data_Wfwd = 32'd0;
        i_addr_rs = 5'd1;    i_addr_rt = 5'd2;    i_addr_rd = 5'd3;
        i_con_Ealusrc = 1'b0; i_con_Eregdst = 1'b1; i_con_Ealupc4 = 1'b0;
        i_con_Mmemread = 1'b0; i_con_Mmemwrite = 1'b0; i_con_Wloadmux = 2'd0;
        i_con_Wmemtoreg = 1'b0; i_con_Wregwrite = 1'b1;
        i_con_fwda = 2'd0;   i_con_fwdb = 2'd0;
    endtask

    // Counts stalled cycles with a fixed bound so a stuck unit still reaches the summary.
    task automatic wait_idle(input int exp, input string tag);
        int n = 0;
        while (o_con_stall && n < 60) begin
            n++;
            tick();
        end
        chk(tag, n, exp);
    endtask

    initial begin
        i_nrst = 1'b0;
        clear(6'h20, 32'd0, 32'd0);
        #12;
        chk("rst_alu", o_data_alu, 32'd0);
        chk("rst_dst", o_addr_dst, 32'd0);
        chk("rst_wreg", o_con_Wregwrite, 32'd0);
        chk("rst_stall", o_con_stall, 32'd0);
        @(negedge i_clk) i_nrst = 1'b1;

        clear(6'h20, 32'd5, 32'd7);
        i_con_Mmemread = 1'b1; i_con_Wloadmux = 2'd2; i_con_Wmemtoreg = 1'b1;
        tick();
        chk("add_alu", o_data_alu, 32'd12);
        chk("add_dst", o_addr_dst, 32'd3);
        chk("add_wreg", o_con_Wregwrite, 32'd1);
        chk("add_ctl", {o_con_Mmemread, o_con_Mmemwrite, o_con_Wloadmux, o_con_Wmemtoreg}, 32'b10101);
        #2 i_nrst = 1'b0;
        #1;
        chk("async_rst_alu", o_data_alu, 32'd0);
        chk("async_rst_dst", o_addr_dst, 32'd0);
        chk("async_rst_wreg", o_con_Wregwrite, 32'd0);
        @(negedge i_clk) i_nrst = 1'b1;

        clear(6'h22, 32'h55, 32'h77);
        i_con_fwda = 2'b10; i_data_Mfwd = 32'h100; i_con_fwdb = 2'b01; i_data_Wfwd = 32'h1;
        tick();
        chk("fwd_sub", o_data_alu, 32'hFF);
        chk("fwd_wrt", o_data_wrt, 32'h1);

        clear(6'h20, 32'd9, 32'd0);
        i_con_fwda = 2'b11; i_data_Mfwd = 32'h100; i_data_Wfwd = 32'h1;
        i_con_Ealusrc = 1'b1; i_data_imm = 32'd1;
        tick();
        chk("fwd_reserved", o_data_alu, 32'd10);

        clear(6'h2A, 32'hFFFFFFFF, 32'd1);
        tick();
        chk("slt", o_data_alu, 32'd1);
        clear(6'h2B, 32'hFFFFFFFF, 32'd1);
        tick();
        chk("sltu", o_data_alu, 32'd0);
        clear(6'h03, 32'd0, 32'h80000000);
        i_data_imm = 32'h100;
        tick();
        chk("sra", o_data_alu, 32'hF8000000);
        i_con_Ealuop = 6'h02;
        tick();
        chk("srl", o_data_alu, 32'h08000000);
        clear(6'h0F, 32'd0, 32'd0);
        i_con_Ealusrc = 1'b1; i_data_imm = 32'h1234;
        tick();
        chk("lui", o_data_alu, 32'h12340000);
        clear(6'h27, 32'd0, 32'd0);
        tick();
        chk("nor", o_data_alu, 32'hFFFFFFFF);
        clear(6'h3F, 32'd4, 32'd5);
        i_con_Eregdst = 1'b0; i_addr_rt = 5'd9;
        tick();
        chk("unknown_op", o_data_alu, 32'd0);
        chk("dst_rt", o_addr_dst, 32'd9);
        clear(6'h20, 32'd1, 32'd5);
        i_con_Ealupc4 = 1'b1; i_con_Eregdst = 1'b0; i_addr_pc4 = 32'h400;
        tick();
        chk("jal_alu", o_data_alu, 32'h404);
        chk("jal_dst", o_addr_dst, 32'd31);

`ifdef EXEC_MULDIV_EN
        clear(6'h18, 32'hFFFFFFFD, 32'd7);
        chk("mult_issue_stall", o_con_stall, 32'd0);
        tick();
        chk("mult_wreg", o_con_Wregwrite, 32'd0);
        clear(6'h12, 32'd0, 32'd0);
        i_addr_rd = 5'd4;
        chk("mflo_stall_first", o_con_stall, 32'd1);
        tick();
        chk("bubble_alu", o_data_alu, 32'd0);
        chk("bubble_wreg", o_con_Wregwrite, 32'd0);
        chk("bubble_dst", o_addr_dst, 32'd0);
        wait_idle(32, "mflo_stall_len");
        tick();
        chk("mult_lo", o_data_alu, 32'hFFFFFFEB);
        chk("mflo_dst", o_addr_dst, 32'd4);
        i_con_Ealuop = 6'h10;
        tick();
        chk("mult_hi", o_data_alu, 32'hFFFFFFFF);

        clear(6'h19, 32'h10000, 32'h10000);
        tick();
        clear(6'h20, 32'd2, 32'd3);
        chk("add_busy_stall", o_con_stall, 32'd0);
        tick();
        chk("add_busy_alu", o_data_alu, 32'd5);
        clear(6'h10, 32'd0, 32'd0);
        wait_idle(32, "mfhi_stall_len");
        tick();
        chk("multu_hi", o_data_alu, 32'd1);
        i_con_Ealuop = 6'h12;
        tick();
        chk("multu_lo", o_data_alu, 32'd0);

        clear(6'h1A, 32'hFFFFFFF9, 32'd2);
        tick();
        clear(6'h12, 32'd0, 32'd0);
        wait_idle(33, "div_stall_len");
        tick();
        chk("div_lo", o_data_alu, 32'hFFFFFFFD);
        i_con_Ealuop = 6'h10;
        tick();
        chk("div_hi", o_data_alu, 32'hFFFFFFFF);

        clear(6'h1B, 32'd5, 32'd0);
        tick();
        clear(6'h12, 32'd0, 32'd0);
        wait_idle(33, "divz_stall_len");
        tick();
        chk("divz_lo", o_data_alu, 32'hFFFFFFFF);
        i_con_Ealuop = 6'h10;
        tick();
        chk("divz_hi", o_data_alu, 32'd5);

        clear(6'h18, 32'd3, 32'd7);
        tick();
        clear(6'h25, 32'd1, 32'd2);
        repeat (9) tick();
        chk("or_busy", o_data_alu, 32'd3);
        i_con_Ealuop = 6'h10;
        chk("busy10_stall", o_con_stall, 32'd1);
        #2 i_nrst = 1'b0;
        #1;
        chk("md_rst_stall", o_con_stall, 32'd0);
        @(negedge i_clk) i_nrst = 1'b1;
        tick();
        chk("md_rst_hi", o_data_alu, 32'd0);
        i_con_Ealuop = 6'h12;
        tick();
        chk("md_rst_lo", o_data_alu, 32'd0);
`else
        clear(6'h18, 32'hFFFFFFFD, 32'd7);
        chk("nomd_mult_stall", o_con_stall, 32'd0);
        tick();
        chk("nomd_mult_alu", o_data_alu, 32'd0);
        chk("nomd_mult_wreg", o_con_Wregwrite, 32'd1);
        clear(6'h12, 32'd0, 32'd0);
        chk("nomd_mflo_stall", o_con_stall, 32'd0);
        tick();
        chk("nomd_mflo", o_data_alu, 32'd0);
        chk("nomd_mflo_wreg", o_con_Wregwrite, 32'd1);
        i_con_Ealuop = 6'h10;
        tick();
        chk("nomd_mfhi", o_data_alu, 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
